// File: rtl/hazard_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_controller: MIPS front-end stall / flush / freeze sequencer.      |
// | Optional perf counters when HAZARD_PERF_COUNTERS_EN is defined. Rev 1.0  |
// +--------------------------------------------------------------------------+
module hazard_controller #(
  parameter int LOAD_USE_STALLS = 1,
  parameter int MEM_TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memReadEx,
  input  logic [4:0]  addressRtEx,
  input  logic [4:0]  addressRsId,
  input  logic [4:0]  addressRtId,
  input  logic        usesRtId,
  input  logic        branchControlId,
  input  logic        jumpId,
  input  logic        memBusyMem,
  output logic        hazard,
  output logic        flushId,
  output logic        freeze,
  output logic        memError
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [31:0] stallCycles,
  output logic [31:0] flushCount,
  output logic [31:0] freezeCycles
`endif
);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_LOAD_STALL = 2'd1,
    S_MEM_WAIT   = 2'd2
  } state_t;

  localparam logic [1:0] c_stall_init = 2'(LOAD_USE_STALLS - 1);
  localparam logic [7:0] c_timeout    = 8'(MEM_TIMEOUT);

  state_t     r_state;
  state_t     r_saved_state;
  state_t     w_next_state;
  logic [1:0] r_stall_cnt;
  logic [7:0] r_busy_cnt;
  logic [7:0] w_busy_inc;
  logic       r_mem_error;
  logic       w_lu;
  logic       w_hazard;
  logic       w_flush;
  logic       w_freeze;

  assign w_lu = memReadEx && (addressRtEx != 5'd0) &&
                ((addressRtEx == addressRsId) || (usesRtId && (addressRtEx == addressRtId)));

  assign w_busy_inc = (r_busy_cnt == 8'hFF) ? r_busy_cnt : r_busy_cnt + 8'd1;

  always_comb begin
    w_next_state = r_state;
    w_hazard     = 1'b0;
    w_flush      = 1'b0;
    w_freeze     = 1'b0;
    case (r_state)
      S_RUN: begin
        if (memBusyMem) begin
          w_freeze     = 1'b1;
          w_next_state = S_MEM_WAIT;
        end else if (w_lu) begin
          w_hazard = 1'b1;
          if (c_stall_init != 2'd0) w_next_state = S_LOAD_STALL;
        end else begin
          w_flush = branchControlId | jumpId;
        end
      end
      S_LOAD_STALL: begin
        if (memBusyMem) begin
          w_freeze     = 1'b1;
          w_next_state = S_MEM_WAIT;
        end else begin
          w_hazard = 1'b1;
          if (r_stall_cnt == 2'd1) w_next_state = S_RUN;
        end
      end
      S_MEM_WAIT: begin
        // The release cycle drops freeze and lets the pipe move once before resuming.
        if (memBusyMem) w_freeze = 1'b1;
        else            w_next_state = r_saved_state;
      end
      default: w_next_state = S_RUN;
    endcase
  end

  assign hazard   = w_hazard & ~reset;
  assign flushId  = w_flush  & ~reset;
  assign freeze   = w_freeze & ~reset;
  assign memError = r_mem_error & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_RUN;
      r_saved_state <= S_RUN;
      r_stall_cnt   <= 2'd0;
      r_busy_cnt    <= 8'd0;
      r_mem_error   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_RUN: begin
          if (memBusyMem) begin
            r_saved_state <= S_RUN;
            r_busy_cnt    <= 8'd1;
          end else if (w_lu) begin
            r_stall_cnt <= c_stall_init;
          end
        end
        S_LOAD_STALL: begin
          if (memBusyMem) begin
            r_saved_state <= S_LOAD_STALL;
            r_busy_cnt    <= 8'd1;
          end else begin
            r_stall_cnt <= r_stall_cnt - 2'd1;
          end
        end
        S_MEM_WAIT: begin
          if (memBusyMem) begin
            r_busy_cnt <= w_busy_inc;
            if (w_busy_inc == c_timeout) r_mem_error <= 1'b1;
          end else begin
            r_busy_cnt <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;
  logic [31:0] r_freeze_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles  <= 32'd0;
      r_flush_count   <= 32'd0;
      r_freeze_cycles <= 32'd0;
    end else begin
      if (hazard  && (r_stall_cycles  != 32'hFFFF_FFFF)) r_stall_cycles  <= r_stall_cycles  + 32'd1;
      if (flushId && (r_flush_count   != 32'hFFFF_FFFF)) r_flush_count   <= r_flush_count   + 32'd1;
      if (freeze  && (r_freeze_cycles != 32'hFFFF_FFFF)) r_freeze_cycles <= r_freeze_cycles + 32'd1;
    end
  end

  assign stallCycles  = r_stall_cycles;
  assign flushCount   = r_flush_count;
  assign freezeCycles = r_freeze_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// Scoreboard bench: three hazard_controller configurations share one stimulus
// stream; a cycle-level reference model predicts outputs, a monitor compares.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       memReadEx;
  logic [4:0] addressRtEx, addressRsId, addressRtId;
  logic       usesRtId, branchControlId, jumpId, memBusyMem;
  logic [2:0] hz, fl, fz, me;

  always #5 clk = ~clk;

  hazard_controller #(.LOAD_USE_STALLS(1), .MEM_TIMEOUT(64)) u_dut0 (
    .clk(clk), .reset(reset), .memReadEx(memReadEx), .addressRtEx(addressRtEx),
    .addressRsId(addressRsId), .addressRtId(addressRtId), .usesRtId(usesRtId),
    .branchControlId(branchControlId), .jumpId(jumpId), .memBusyMem(memBusyMem),
    .hazard(hz[0]), .flushId(fl[0]), .freeze(fz[0]), .memError(me[0]));

  hazard_controller #(.LOAD_USE_STALLS(2), .MEM_TIMEOUT(64)) u_dut1 (
    .clk(clk), .reset(reset), .memReadEx(memReadEx), .addressRtEx(addressRtEx),
    .addressRsId(addressRsId), .addressRtId(addressRtId), .usesRtId(usesRtId),
    .branchControlId(branchControlId), .jumpId(jumpId), .memBusyMem(memBusyMem),
    .hazard(hz[1]), .flushId(fl[1]), .freeze(fz[1]), .memError(me[1]));

  hazard_controller #(.LOAD_USE_STALLS(3), .MEM_TIMEOUT(4)) u_dut2 (
    .clk(clk), .reset(reset), .memReadEx(memReadEx), .addressRtEx(addressRtEx),
    .addressRsId(addressRsId), .addressRtId(addressRtId), .usesRtId(usesRtId),
    .branchControlId(branchControlId), .jumpId(jumpId), .memBusyMem(memBusyMem),
    .hazard(hz[2]), .flushId(fl[2]), .freeze(fz[2]), .memError(me[2]));

  function automatic int lus_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 3;
  endfunction

  function automatic int mt_of(input int i);
    return (i == 2) ? 4 : 64;
  endfunction

  // Reference model state: remaining extra stall cycles, waiting on memory,
  // length of the current busy run, sticky error.
  int         m_stall_left[3];
  bit         m_wait[3];
  int         m_busy_len[3];
  bit         m_err[3];
  logic [11:0] exp_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;

  // Expected vector per DUT: {memError, freeze, flushId, hazard}
  task automatic model(input int i, output logic [3:0] e);
    bit lu;
    e  = 4'b0000;
    lu = memReadEx && (addressRtEx != 0) &&
         ((addressRtEx == addressRsId) || (usesRtId && (addressRtEx == addressRtId)));
    if (reset) begin
      m_stall_left[i] = 0;
      m_wait[i]       = 0;
      m_busy_len[i]   = 0;
      m_err[i]        = 0;
      return;
    end
    e[3] = m_err[i];
    if (memBusyMem) begin
      e[2] = 1'b1;
      m_wait[i] = 1;
      if (m_busy_len[i] < 255) m_busy_len[i]++;
      if (m_busy_len[i] >= mt_of(i)) m_err[i] = 1;
    end else if (m_wait[i]) begin
      m_wait[i]     = 0;
      m_busy_len[i] = 0;
    end else if (m_stall_left[i] > 0) begin
      e[0] = 1'b1;
      m_stall_left[i]--;
    end else if (lu) begin
      e[0] = 1'b1;
      m_stall_left[i] = lus_of(i) - 1;
    end else begin
      e[1] = branchControlId | jumpId;
    end
  endtask

  task automatic step(input logic r, input logic mr, input logic [4:0] rtex,
                      input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                      input logic br, input logic jp, input logic busy);
    logic [11:0] exp;
    logic [3:0]  e;
    @(posedge clk);
    #1;
    reset = r; memReadEx = mr; addressRtEx = rtex; addressRsId = rs;
    addressRtId = rt; usesRtId = ur; branchControlId = br; jumpId = jp; memBusyMem = busy;
    exp = '0;
    for (int i = 0; i < 3; i++) begin
      model(i, e);
      exp[i*4 +: 4] = e;
    end
    exp_q.push_back(exp);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    logic [11:0] exp;
    logic [3:0]  got;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      for (int i = 0; i < 3; i++) begin
        got = {me[i], fz[i], fl[i], hz[i]};
        n_cmp++;
        if (got !== exp[i*4 +: 4]) begin
          n_fail++;
          $display("FAIL outputs dut%0d t=%0t {memError,freeze,flushId,hazard} got=%b expected=%b",
                   i, $time, got, exp[i*4 +: 4]);
        end
      end
    end
  end

  initial begin
    int busy_left;
    reset = 1; memReadEx = 0; addressRtEx = 0; addressRsId = 0; addressRtId = 0;
    usesRtId = 0; branchControlId = 0; jumpId = 0; memBusyMem = 0;

    // Reset held with every input active
    for (int k = 0; k < 3; k++) step(1, 1, 5'd8, 5'd8, 5'd8, 1, 1, 1, 1);
    idle(2);
    // Single-cycle load-use on rs
    step(0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0);
    idle(4);
    // Load-use on rt
    step(0, 1, 5'd9, 5'd0, 5'd9, 1, 0, 0, 0);
    idle(4);
    // rt match ignored when rt is not a source
    step(0, 1, 5'd9, 5'd0, 5'd9, 0, 0, 0, 0);
    idle(1);
    // Load to $0 never stalls
    step(0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
    idle(1);
    // Load-use with taken branch, then branch held alone
    step(0, 1, 5'd3, 5'd3, 5'd0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 5'd3, 5'd3, 5'd0, 0, 1, 0, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    idle(2);
    // Long memory busy beyond the timeout, then release; error stays sticky
    for (int k = 0; k < 70; k++) step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
    idle(5);
    // Busy arriving in the middle of a load stall
    step(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0);
    step(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 1);
    step(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 1);
    idle(5);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    idle(2);

    busy_left = 0;
    for (int k = 0; k < 3000; k++) begin
      logic b;
      if (busy_left > 0) begin
        b = 1'b1;
        busy_left--;
      end else if ($urandom_range(0, 19) == 0) begin
        busy_left = $urandom_range(0, 9);
        b = 1'b1;
      end else begin
        b = 1'b0;
      end
      step(($urandom_range(0, 249) == 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), b);
    end

    repeat (2) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
